uart_config_responder: RTL and testbench
========================================

UART_CONFIG_RESPONDER -- requirements
Module: uart_config_responder

Interface
REQ-001 SHALL have parameter SYN_NUMBER, default 3: consecutive SYN bytes that open a configuration session.
REQ-002 SHALL have parameter SYN_CHAR, default 8'h16: SYN byte value.
REQ-003 SHALL have parameter ACK_CHAR, default 8'h06: acknowledge byte.
REQ-004 SHALL have parameter NACK_CHAR, default 8'h15: negative-acknowledge byte.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000: idle cycles in WAIT_CMD before abort (used only with CONFIG_TIMEOUT_EN).
REQ-006 SHALL have port clk_i  input  1  system clock; all logic on the rising edge.
REQ-007 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port rx_data_i  input  8  received byte.
REQ-009 SHALL have port rx_valid_i  input  1  single-cycle strobe, rx_data_i valid.
REQ-010 SHALL have port tx_data_o  output  8  response byte to the transmitter.
REQ-011 SHALL have port tx_valid_o  output  1  response byte valid.
REQ-012 SHALL have port tx_ready_i  input  1  transmitter accepts tx_data_o when high with tx_valid_o.
REQ-013 SHALL have port data_width_o  output  2  committed data width code.
REQ-014 SHALL have port parity_mode_o  output  2  committed parity mode code.
REQ-015 SHALL have port stop_bits_o  output  2  committed stop bits code.
REQ-016 SHALL have port config_active_o  output  1  high while a session is open.
REQ-017 SHALL have port int_config_req_o  output  1  one-cycle pulse at session open.
REQ-018 SHALL have port int_config_fail_o  output  1  one-cycle pulse at session abort.

Function
REQ-019 SHALL implement states IDLE, SEND_ACK, WAIT_CMD, SEND_NACK, with a sub-flag marking a final ACK after END.
REQ-020 SHALL count consecutive rx_valid_i bytes equal to SYN_CHAR in IDLE; any other byte clears the count to 0.
REQ-021 SHALL, on the SYN_NUMBER-th consecutive SYN, pulse int_config_req_o the next cycle, set config_active_o, copy committed config into a shadow set and enter SEND_ACK.
REQ-022 SHALL decode command byte as bits[1:0] = ID, bits[3:2] = code, bits[7:4] must be 0.
REQ-023 SHALL treat ID 01/10/11 as data width/parity/stop bits writes to the shadow set and ID 00 as END.
REQ-024 SHALL reject a byte with nonzero bits[7:4], or ID 11 with code 10/11, by entering SEND_NACK.
REQ-025 SHALL, on END, copy shadow into data_width_o/parity_mode_o/stop_bits_o in the same cycle as the transition into SEND_ACK.
REQ-026 SHALL hold tx_valid_o high and tx_data_o stable in SEND_ACK/SEND_NACK until tx_ready_i; handshake cycle exits the state.
REQ-027 SHALL go from SEND_ACK to WAIT_CMD after a command ACK, and to IDLE (config_active_o low) after the END ACK.
REQ-028 SHALL, in SEND_NACK handshake, pulse int_config_fail_o, discard shadow, clear config_active_o and return to IDLE.
REQ-029 SHALL ignore rx_valid_i bytes arriving in SEND_ACK or SEND_NACK (no state or shadow change).
REQ-030 SHALL clear the SYN count on every return to IDLE.

Reset
REQ-031 SHALL on rst_n_i low, immediately: state IDLE, SYN count 0, tx_valid_o 0, tx_data_o 8'h00, config_active_o 0, both interrupts 0.
REQ-032 SHALL reset data_width_o 2'b11, parity_mode_o 2'b00, stop_bits_o 2'b00 (8 bit, even, 1 stop); shadow to same.
REQ-033 SHALL, on reset mid-session, discard the session without committing and without any response byte.

Configuration
REQ-034 SHALL, with macro UART_CONFIG_TIMEOUT_EN defined, count cycles in WAIT_CMD without rx_valid_i, reset the count on each byte, and at TIMEOUT_CYCLES enter SEND_NACK.
REQ-035 SHALL, without UART_CONFIG_TIMEOUT_EN, wait in WAIT_CMD indefinitely and contain no timeout counter.

Verification
REQ-036 SHALL cover: bytes 16,16,16 with tx_ready_i=1 -> int_config_req_o pulse, tx_data_o 8'h06, config_active_o 1.
REQ-037 SHALL cover: session then 8'h09, 8'h06, 8'h07, 8'h00 -> four ACKs; outputs change only after 8'h00 to width 2'b10, parity 2'b01, stop 2'b01.
REQ-038 SHALL cover: 16,16,41,16,16 -> no session opened, no tx_valid_o.
REQ-039 SHALL cover: session then 8'h0B -> tx_data_o 8'h15, int_config_fail_o pulse, outputs keep reset values.
REQ-040 SHALL cover: tx_ready_i held 0 for 10 cycles in SEND_ACK with rx byte 8'h00 injected -> tx_valid_o/tx_data_o stable, byte ignored, still WAIT_CMD after handshake.
REQ-041 SHALL cover: with UART_CONFIG_TIMEOUT_EN and TIMEOUT_CYCLES=100, session then silence -> 8'h15 after 100 cycles, config_active_o 0; rst_n_i pulse mid-session -> IDLE, no commit.

Source files
------------

// File: rtl/uart_config_responder.sv
// uart_config_responder
//
// Listens to the UART receive byte stream for a run of SYN_NUMBER consecutive
// SYN_CHAR bytes. That run opens a configuration session. Inside a session,
// each command byte is answered with ACK_CHAR or NACK_CHAR on the transmit
// side. Accepted writes go to a shadow copy of the line settings. The END
// command commits the shadow copy to the outputs and closes the session. A
// rejected command, or a timeout when that feature is built in, throws the
// shadow away and closes the session.
//
// Command byte layout:
//   [7:4] must be 0
//   [3:2] code
//   [1:0] ID: 00 = END, 01 = data width, 10 = parity, 11 = stop bits
//
// Optional feature: define UART_CONFIG_TIMEOUT_EN to abort a session after
// TIMEOUT_CYCLES consecutive cycles in WAIT_CMD with no received byte.
//
// Ports:
//   clk_i             system clock, rising edge
//   rst_n_i           asynchronous active-low reset
//   rx_data_i[7:0]    received byte
//   rx_valid_i        one-cycle strobe, rx_data_i valid
//   tx_data_o[7:0]    response byte (ACK/NACK)
//   tx_valid_o        response byte valid
//   tx_ready_i        transmitter accepts the response byte
//   data_width_o[1:0] committed data width code
//   parity_mode_o[1:0] committed parity mode code
//   stop_bits_o[1:0]  committed stop bits code
//   config_active_o   high while a session is open
//   int_config_req_o  one-cycle pulse when a session opens
//   int_config_fail_o one-cycle pulse when a session aborts
module uart_config_responder #(
  parameter int          SYN_NUMBER     = 3,
  parameter logic [7:0]  SYN_CHAR       = 8'h16,
  parameter logic [7:0]  ACK_CHAR       = 8'h06,
  parameter logic [7:0]  NACK_CHAR      = 8'h15,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic [1:0] data_width_o,
  output logic [1:0] parity_mode_o,
  output logic [1:0] stop_bits_o,
  output logic       config_active_o,
  output logic       int_config_req_o,
  output logic       int_config_fail_o
);

  localparam int SYN_CNT_W = $clog2(SYN_NUMBER + 1);

  // Reset values: 8 data bits, even parity, 1 stop bit.
  localparam logic [1:0] RST_WIDTH  = 2'b11;
  localparam logic [1:0] RST_PARITY = 2'b00;
  localparam logic [1:0] RST_STOP   = 2'b00;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_ACK  = 2'd1,
    WAIT_CMD  = 2'd2,
    SEND_NACK = 2'd3
  } state_t;

  state_t state, state_nxt;
  // Set while SEND_ACK is answering END, so the handshake closes the session.
  logic   end_ack, end_ack_nxt;

  logic [SYN_CNT_W-1:0] syn_cnt;
  logic [1:0]           sh_width, sh_parity, sh_stop;

  logic       syn_match;
  logic [1:0] cmd_id;
  logic [1:0] cmd_code;
  logic       cmd_bad;
  logic       open_session;
  logic       cmd_write;
  logic       cmd_end;
  logic       nack_done;
  logic       timeout_hit;

  assign syn_match = (rx_data_i == SYN_CHAR);
  assign cmd_id    = rx_data_i[1:0];
  assign cmd_code  = rx_data_i[3:2];
  // Stop-bit codes 10/11 are not defined, so they are rejected like a bad header.
  assign cmd_bad   = (rx_data_i[7:4] != 4'h0) || ((cmd_id == 2'b11) && cmd_code[1]);

`ifdef UART_CONFIG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // The count restarts on every received byte and whenever the FSM leaves WAIT_CMD.
  assign timeout_hit = (state == WAIT_CMD) && !rx_valid_i &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_cnt <= '0;
    end else if ((state == WAIT_CMD) && !rx_valid_i && !timeout_hit) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      end_ack <= 1'b0;
    end else begin
      state   <= state_nxt;
      end_ack <= end_ack_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    end_ack_nxt  = end_ack;
    open_session = 1'b0;
    cmd_write    = 1'b0;
    cmd_end      = 1'b0;
    nack_done    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid_i && syn_match && (syn_cnt == SYN_CNT_W'(SYN_NUMBER - 1))) begin
          open_session = 1'b1;
          end_ack_nxt  = 1'b0;
          state_nxt    = SEND_ACK;
        end
      end
      WAIT_CMD: begin
        if (rx_valid_i) begin
          if (cmd_bad) begin
            state_nxt = SEND_NACK;
          end else if (cmd_id == 2'b00) begin
            cmd_end     = 1'b1;
            end_ack_nxt = 1'b1;
            state_nxt   = SEND_ACK;
          end else begin
            cmd_write   = 1'b1;
            end_ack_nxt = 1'b0;
            state_nxt   = SEND_ACK;
          end
        end else if (timeout_hit) begin
          state_nxt = SEND_NACK;
        end
      end
      SEND_ACK: begin
        if (tx_ready_i) begin
          state_nxt   = end_ack ? IDLE : WAIT_CMD;
          end_ack_nxt = 1'b0;
        end
      end
      SEND_NACK: begin
        if (tx_ready_i) begin
          nack_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The response byte comes straight from the state, so it is stable for the whole stall.
  always_comb begin
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    if (state == SEND_ACK) begin
      tx_valid_o = 1'b1;
      tx_data_o  = ACK_CHAR;
    end else if (state == SEND_NACK) begin
      tx_valid_o = 1'b1;
      tx_data_o  = NACK_CHAR;
    end
  end

  assign config_active_o = (state != IDLE);

  // The SYN run only advances in IDLE. It is held at zero everywhere else, so
  // every return to IDLE starts counting from scratch.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      syn_cnt <= '0;
    end else if ((state != IDLE) || open_session) begin
      syn_cnt <= '0;
    end else if (rx_valid_i) begin
      syn_cnt <= syn_match ? (syn_cnt + SYN_CNT_W'(1)) : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh_width  <= RST_WIDTH;
      sh_parity <= RST_PARITY;
      sh_stop   <= RST_STOP;
    end else if (open_session || nack_done) begin
      // Opening snapshots the live settings. An abort discards the edits the same way.
      sh_width  <= data_width_o;
      sh_parity <= parity_mode_o;
      sh_stop   <= stop_bits_o;
    end else if (cmd_write) begin
      case (cmd_id)
        2'b01:   sh_width  <= cmd_code;
        2'b10:   sh_parity <= cmd_code;
        default: sh_stop   <= cmd_code;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_width_o  <= RST_WIDTH;
      parity_mode_o <= RST_PARITY;
      stop_bits_o   <= RST_STOP;
    end else if (cmd_end) begin
      data_width_o  <= sh_width;
      parity_mode_o <= sh_parity;
      stop_bits_o   <= sh_stop;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      int_config_req_o  <= 1'b0;
      int_config_fail_o <= 1'b0;
    end else begin
      int_config_req_o  <= open_session;
      int_config_fail_o <= nack_done;
    end
  end

endmodule

// File: tb/tb_uart_config_responder.sv
// Testbench for uart_config_responder. The bench sends bytes one at a time
// and predicts the responder's reply with a byte-level model of the session
// rules. It runs directed scenarios first, then randomized traffic with
// random transmitter stalls and stray bytes during the response phase.
module tb_uart_config_responder;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] data_width;
  logic [1:0] parity_mode;
  logic [1:0] stop_bits;
  logic       config_active;
  logic       int_req;
  logic       int_fail;

  int total;
  int bad;

  uart_config_responder #(
    .SYN_NUMBER(3),
    .SYN_CHAR(8'h16),
    .ACK_CHAR(8'h06),
    .NACK_CHAR(8'h15),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .rx_data_i(rx_data),
    .rx_valid_i(rx_valid),
    .tx_data_o(tx_data),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .data_width_o(data_width),
    .parity_mode_o(parity_mode),
    .stop_bits_o(stop_bits),
    .config_active_o(config_active),
    .int_config_req_o(int_req),
    .int_config_fail_o(int_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the session as seen from the byte stream.
  logic [1:0] m_com [1:3];
  logic [1:0] m_sh  [1:3];
  int         m_run;
  bit         m_sess;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_com[1] = 2'b11; m_com[2] = 2'b00; m_com[3] = 2'b00;
    m_sh = m_com;
    m_run = 0;
    m_sess = 1'b0;
  endfunction

  // Returns 0 = no reply, 1 = ACK, 2 = NACK. Sets opened when this byte opens a session.
  function automatic int model_byte(input logic [7:0] b, output bit opened);
    int id;
    opened = 1'b0;
    if (!m_sess) begin
      if (b == 8'h16) begin
        m_run = m_run + 1;
        if (m_run == 3) begin
          m_run = 0;
          m_sess = 1'b1;
          m_sh = m_com;
          opened = 1'b1;
          return 1;
        end
      end else begin
        m_run = 0;
      end
      return 0;
    end
    id = int'(b[1:0]);
    if (b[7:4] != 4'h0 || (id == 3 && b[3])) begin
      m_sess = 1'b0;
      return 2;
    end
    if (id == 0) begin
      m_com = m_sh;
      m_sess = 1'b0;
      return 1;
    end
    m_sh[id] = b[3:2];
    return 1;
  endfunction

  task automatic chk_cfg(input string tag);
    chk({tag, "_width"},  {30'd0, data_width},  {30'd0, m_com[1]});
    chk({tag, "_parity"}, {30'd0, parity_mode}, {30'd0, m_com[2]});
    chk({tag, "_stop"},   {30'd0, stop_bits},   {30'd0, m_com[3]});
  endtask

  // Sends one byte, then checks and completes the reply. The transmitter
  // stalls for `stall` cycles before accepting, optionally with a stray rx byte.
  task automatic send_byte(input logic [7:0] b, input int stall, input bit inject,
                           input logic [7:0] inj);
    int  r;
    bit  opened;
    logic [7:0] exp;
    r = model_byte(b, opened);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("req_pulse", {31'd0, int_req}, {31'd0, opened});
    if (r == 0) begin
      chk("tx_valid_none", {31'd0, tx_valid}, 32'd0);
      chk("active_none", {31'd0, config_active}, {31'd0, m_sess});
      chk_cfg("none");
    end else begin
      exp = (r == 1) ? 8'h06 : 8'h15;
      chk("tx_valid_rsp", {31'd0, tx_valid}, 32'd1);
      chk("tx_data_rsp", {24'd0, tx_data}, {24'd0, exp});
      chk("active_rsp", {31'd0, config_active}, 32'd1);
      chk_cfg("rsp");
      for (int i = 0; i < stall; i++) begin
        rx_valid = inject; rx_data = inj;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("tx_valid_stall", {31'd0, tx_valid}, 32'd1);
        chk("tx_data_stall", {24'd0, tx_data}, {24'd0, exp});
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      chk("tx_valid_done", {31'd0, tx_valid}, 32'd0);
      chk("fail_pulse", {31'd0, int_fail}, {31'd0, (r == 2)});
      chk("active_done", {31'd0, config_active}, {31'd0, m_sess});
      chk_cfg("done");
    end
  endtask

  task automatic open_session();
    for (int i = 0; i < 3; i++) send_byte(8'h16, 0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_active", {31'd0, config_active}, 32'd0);
    chk("rst_req", {31'd0, int_req}, 32'd0);
    chk("rst_fail", {31'd0, int_fail}, 32'd0);
    chk_cfg("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int sel;
    total = 0; bad = 0;
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    model_reset();
    #12;
    do_reset();

    // Session open, acknowledged.
    open_session();
    // Settings change only once END arrives.
    send_byte(8'h09, 0, 1'b0, 8'h00);
    send_byte(8'h06, 2, 1'b0, 8'h00);
    send_byte(8'h07, 0, 1'b0, 8'h00);
    send_byte(8'h00, 1, 1'b0, 8'h00);
    chk("commit_width", {30'd0, data_width}, 32'd2);
    chk("commit_parity", {30'd0, parity_mode}, 32'd1);
    chk("commit_stop", {30'd0, stop_bits}, 32'd1);

    // Broken SYN run opens nothing.
    do_reset();
    send_byte(8'h16, 0, 1'b0, 8'h00);
    send_byte(8'h16, 0, 1'b0, 8'h00);
    send_byte(8'h41, 0, 1'b0, 8'h00);
    send_byte(8'h16, 0, 1'b0, 8'h00);
    send_byte(8'h16, 0, 1'b0, 8'h00);

    // Stop-bit code 10 is rejected and the outputs keep their reset values.
    send_byte(8'h16, 0, 1'b0, 8'h00);
    send_byte(8'h05, 0, 1'b0, 8'h00);
    send_byte(8'h0B, 0, 1'b0, 8'h00);
    chk("nack_keep_width", {30'd0, data_width}, 32'd3);

    // A long stall with a stray END must leave the session in WAIT_CMD.
    open_session();
    send_byte(8'h05, 10, 1'b1, 8'h00);
    chk("stall_still_active", {31'd0, config_active}, 32'd1);
    send_byte(8'h00, 0, 1'b0, 8'h00);
    chk("stall_commit_width", {30'd0, data_width}, 32'd1);

    // Reset in the middle of a session drops it without committing.
    open_session();
    send_byte(8'h0D, 0, 1'b0, 8'h00);
    do_reset();
    send_byte(8'h00, 0, 1'b0, 8'h00);

`ifdef UART_CONFIG_TIMEOUT_EN
    begin
      int n;
      open_session();
      n = 0;
      for (int i = 1; i <= 200; i++) begin
        @(negedge clk);
        if (tx_valid) begin n = i; break; end
      end
      chk("timeout_cycles", n, 32'd100);
      chk("timeout_data", {24'd0, tx_data}, 32'h15);
      m_sess = 1'b0;
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      chk("timeout_fail", {31'd0, int_fail}, 32'd1);
      chk("timeout_active", {31'd0, config_active}, 32'd0);
      chk_cfg("timeout");
    end
`endif

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 99);
      if (sel < 40)      b = 8'h16;
      else if (sel < 85) b = 8'($urandom_range(0, 15));
      else               b = 8'($urandom);
      send_byte(b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
